// File: rtl/osc_clken_gen.sv
// Programmable multi-channel clock-enable generator in the RC-oscillator domain.
// Channels stay idle for a settle interval, then emit strobes and 50% toggles per divisor.
module osc_clken_gen #(
  parameter int N_CH           = 4,
  parameter int CH_W           = 2,
  parameter int DIV_W          = 16,
  parameter int DEFAULT_DIV    = 50,
  parameter int STARTUP_CYCLES = 1024
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WR_EN,
  input  logic [CH_W-1:0]   WR_CH,
  input  logic [DIV_W-1:0]  WR_DATA,
  input  logic [N_CH-1:0]   CH_EN,
  output logic              READY,
  output logic [N_CH-1:0]   STROBE,
  output logic [N_CH-1:0]   TOGGLE,
  output logic              ERR
);

  localparam int SET_W = $clog2(STARTUP_CYCLES + 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(STARTUP_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);
  localparam logic [CH_W:0]    NCH_C    = (CH_W + 1)'(N_CH);

  logic [SET_W-1:0] settle_q, settle_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic [N_CH-1:0]  strobe_q, strobe_d;
  logic [N_CH-1:0]  toggle_q, toggle_d;
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [DIV_W-1:0] cnt_q [N_CH];
  logic [DIV_W-1:0] cnt_d [N_CH];
  logic [DIV_W-1:0] div_q [N_CH];
  logic [DIV_W-1:0] div_d [N_CH];
  logic [DIV_W-1:0] shadow_q [N_CH];
  logic [DIV_W-1:0] shadow_d [N_CH];

  logic             wr_legal_s;
  logic             wr_illegal_s;
  logic [N_CH-1:0]  active_s;
  logic [N_CH-1:0]  tc_s;
  logic [N_CH-1:0]  hit_s;

  // Write qualification and per-channel status decode
  always_comb begin
    wr_legal_s   = WR_EN && ({1'b0, WR_CH} < NCH_C) && (WR_DATA >= DIV_W'(2));
    wr_illegal_s = WR_EN && !wr_legal_s;
    active_s     = '0;
    tc_s         = '0;
    hit_s        = '0;
    for (int c = 0; c < N_CH; c++) begin
      active_s[c] = ready_q && CH_EN[c];
      tc_s[c]     = (cnt_q[c] == (div_q[c] - DIV_W'(1)));
      hit_s[c]    = wr_legal_s && (WR_CH == CH_W'(c));
    end
  end

  // Settle counter, ready and sticky error
  always_comb begin
    settle_d = settle_q;
    ready_d  = ready_q;
    if (!ready_q) begin
      settle_d = settle_q + SET_W'(1);
      if (settle_q == SET_LAST) begin
        ready_d = 1'b1;
      end else begin
        ready_d = 1'b0;
      end
    end else begin
      settle_d = settle_q;
    end
    if (wr_illegal_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Per-channel counting; a write landing this edge defers any divisor reload
  always_comb begin
    strobe_d = strobe_q;
    toggle_d = toggle_q;
    pend_d   = pend_q;
    for (int c = 0; c < N_CH; c++) begin
      cnt_d[c]    = cnt_q[c];
      div_d[c]    = div_q[c];
      shadow_d[c] = shadow_q[c];
      if (active_s[c]) begin
        if (tc_s[c]) begin
          cnt_d[c]    = '0;
          strobe_d[c] = 1'b1;
          toggle_d[c] = ~toggle_q[c];
          if (pend_q[c] && !hit_s[c]) begin
            div_d[c]  = shadow_q[c];
            pend_d[c] = 1'b0;
          end else begin
            div_d[c]  = div_q[c];
          end
        end else begin
          cnt_d[c]    = cnt_q[c] + DIV_W'(1);
          strobe_d[c] = 1'b0;
        end
      end else begin
        cnt_d[c]    = '0;
        strobe_d[c] = 1'b0;
        toggle_d[c] = 1'b0;
        if (pend_q[c] && !hit_s[c]) begin
          div_d[c]  = shadow_q[c];
          pend_d[c] = 1'b0;
        end else begin
          div_d[c]  = div_q[c];
        end
      end
      if (hit_s[c]) begin
        shadow_d[c] = WR_DATA;
        pend_d[c]   = 1'b1;
      end else begin
        shadow_d[c] = shadow_q[c];
      end
    end
  end

  // State registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      settle_q <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      strobe_q <= '0;
      toggle_q <= '0;
      pend_q   <= '0;
      for (int c = 0; c < N_CH; c++) begin
        cnt_q[c]    <= '0;
        div_q[c]    <= DIV_RST;
        shadow_q[c] <= DIV_RST;
      end
    end else begin
      settle_q <= settle_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      strobe_q <= strobe_d;
      toggle_q <= toggle_d;
      pend_q   <= pend_d;
      for (int c = 0; c < N_CH; c++) begin
        cnt_q[c]    <= cnt_d[c];
        div_q[c]    <= div_d[c];
        shadow_q[c] <= shadow_d[c];
      end
    end
  end

  assign READY  = ready_q;
  assign STROBE = strobe_q;
  assign TOGGLE = toggle_q;
  assign ERR    = err_q;

endmodule
